// File: rtl/fp_add_arbiter_if.sv
// Bundle of the requester, adder and response signals of fp_add_arbiter.
// master = requesters plus external adder; slave = the arbiter itself.
interface fp_add_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int LAT     = 2
);
  localparam int INF_W = $clog2(LAT + 3);

  logic                        en_i;
  logic [NUM_REQ-1:0]          req_valid_i;
  logic [NUM_REQ-1:0]          req_ready_o;
  logic [NUM_REQ*DATA_W-1:0]   req_op_a_i;
  logic [NUM_REQ*DATA_W-1:0]   req_op_b_i;
  logic                        add_valid_o;
  logic [DATA_W-1:0]           add_op_a_o;
  logic [DATA_W-1:0]           add_op_b_o;
  logic [DATA_W-1:0]           add_res_i;
  logic [NUM_REQ-1:0]          rsp_valid_o;
  logic [DATA_W-1:0]           rsp_data_o;
  logic [INF_W-1:0]            inflight_o;

  modport master (
    output en_i, req_valid_i, req_op_a_i, req_op_b_i, add_res_i,
    input  req_ready_o, add_valid_o, add_op_a_o, add_op_b_o,
           rsp_valid_o, rsp_data_o, inflight_o
  );

  modport slave (
    input  en_i, req_valid_i, req_op_a_i, req_op_b_i, add_res_i,
    output req_ready_o, add_valid_o, add_op_a_o, add_op_b_o,
           rsp_valid_o, rsp_data_o, inflight_o
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one fully pipelined fixed-latency FP adder
// among NUM_REQ requesters; results return in issue order to the owner.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int LAT     = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fp_add_arbiter_if.slave  bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int INF_W = $clog2(LAT + 3);

  // Handshake: req_valid_i[k] && req_ready_o[k] at a rising edge transfers
  // requester k's operands. Ready may depend on valid (only a valid requester
  // is granted); valid must not depend on ready. Responses cannot be stalled.

  function automatic logic [ID_W-1:0] scan_idx(input logic [ID_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[ID_W-1:0];
  endfunction

  logic [ID_W-1:0]    ptr_q;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] grant;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic               hs;

  // Tag stage 0 is the issue register itself; stage LAT lines up with add_res_i.
  logic [LAT:0]       tag_v;
  logic [ID_W-1:0]    tag_id [0:LAT];
  logic [DATA_W-1:0]  op_a_q;
  logic [DATA_W-1:0]  op_b_q;

  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_any;
  logic [INF_W-1:0]   inflight_q;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    if (bus.en_i && !rst_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && bus.req_valid_i[scan_idx(ptr_q, i)]) begin
          grant_any = 1'b1;
          grant_id  = scan_idx(ptr_q, i);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    sel_a = '0;
    sel_b = '0;
    if (grant_any) grant = NUM_REQ'(1) << grant_id;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_a = bus.req_op_a_i[k*DATA_W +: DATA_W];
        sel_b = bus.req_op_b_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign hs              = grant_any;
  assign bus.req_ready_o = grant;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      tag_v  <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      for (int i = 0; i <= LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_v <= {tag_v[LAT-1:0], hs};
      for (int i = 1; i <= LAT; i++) tag_id[i] <= tag_id[i-1];
      if (hs) begin
        ptr_q     <= scan_idx(grant_id, 1);
        tag_id[0] <= grant_id;
        op_a_q    <= sel_a;
        op_b_q    <= sel_b;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (tag_v[LAT]) begin
        rsp_valid_q <= NUM_REQ'(1) << tag_id[LAT];
        rsp_data_q  <= bus.add_res_i;
      end
    end
  end

  assign rsp_any = |rsp_valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= '0;
    end else begin
      case ({hs, rsp_any})
        2'b10:   inflight_q <= inflight_q + INF_W'(1);
        2'b01:   inflight_q <= inflight_q - INF_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign bus.add_valid_o = tag_v[0];
  assign bus.add_op_a_o  = op_a_q;
  assign bus.add_op_b_o  = op_b_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.inflight_o  = inflight_q;

  a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(bus.req_ready_o));
  a_inflight_max: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(inflight_q) <= LAT + 2);
endmodule
